// File: rtl/blake_pkg.sv
// rtl/blake_pkg.sv - shared sigma table, round constants, rotations and enums for the BLAKE round engine
package blake_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic {COL, DIAG} phase_t;

   // Row r holds sigma_r; element 0 sits in the leftmost nibble.
   localparam logic [0:9][0:15][3:0] SIGMA = {
      64'h0123456789ABCDEF,
      64'hEA489FD61C02B753,
      64'hB8C052FDAE367194,
      64'h7931DCBE265A40F8,
      64'h905724AFE1BC683D,
      64'h2C6A0B834D75FE19,
      64'hC51FED4A0763928B,
      64'hDB7EC13950F4862A,
      64'h6FE9B308C2D714A5,
      64'hA2847615FB9E3CD0
   };

   localparam logic [0:15][31:0] C256 = {
      32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
      32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
      32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
      32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917
   };

   localparam logic [0:15][63:0] C512 = {
      64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
      64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
      64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
      64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
   };

   function automatic logic [63:0] blake_const(input int w, input logic [3:0] idx);
      if (w == 64) return C512[idx];
      return {32'h0, C256[idx]};
   endfunction

   function automatic int rot_amt(input int w, input int k);
      case (k)
         0:       return (w == 64) ? 32 : 16;
         1:       return (w == 64) ? 25 : 12;
         2:       return (w == 64) ? 16 : 8;
         default: return (w == 64) ? 11 : 7;
      endcase
   endfunction

endpackage

// File: rtl/blake_g_param.sv
// rtl/blake_g_param.sv - combinational BLAKE G function for a W-bit word
module blake_g_param
   import blake_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   input  logic [W-1:0] m0,
   input  logic [W-1:0] m1,
   input  logic [W-1:0] k0,
   input  logic [W-1:0] k1,
   output logic [W-1:0] a_new,
   output logic [W-1:0] b_new,
   output logic [W-1:0] c_new,
   output logic [W-1:0] d_new
);

   localparam int R1 = rot_amt(W, 0);
   localparam int R2 = rot_amt(W, 1);
   localparam int R3 = rot_amt(W, 2);
   localparam int R4 = rot_amt(W, 3);

   function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int r);
      return (x >> r) | (x << (W - r));
   endfunction

   logic [W-1:0] a1, b1, c1, d1;

   always_comb begin
      a1    = a + b + (m0 ^ k0);
      d1    = rotr(d ^ a1, R1);
      c1    = c + d1;
      b1    = rotr(b ^ c1, R2);
      a_new = a1 + b1 + (m1 ^ k1);
      d_new = rotr(d1 ^ a_new, R3);
      c_new = c1 + d_new;
      b_new = rotr(b1 ^ c_new, R4);
   end

endmodule

// File: rtl/blake_round_engine.sv
// rtl/blake_round_engine.sv - iterative BLAKE round engine, one half-round (four G) per clock
module blake_round_engine
   import blake_pkg::*;
#(
   parameter int W      = 32,
   parameter int ROUNDS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [16*W-1:0] in_v,
   input  logic [16*W-1:0] in_m,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [16*W-1:0] out_v,
   output logic            busy
);

   if (W != 32 && W != 64) begin : g_bad_w
      $error("blake_round_engine: W must be 32 or 64");
   end
   if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
      $error("blake_round_engine: ROUNDS must be in 1..16");
   end

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

   state_t       state, state_next;
   phase_t       phase;
   logic [3:0]   round_cnt;
   logic [3:0]   sigma_idx;
   logic         accept;
   logic [W-1:0] v_reg  [16];
   logic [W-1:0] m_reg  [16];
   logic [W-1:0] v_half [16];
   logic [W-1:0] ga [4], gb [4], gc [4], gd [4];
   logic [W-1:0] ya [4], yb [4], yc [4], yd [4];
   logic [W-1:0] gm0 [4], gm1 [4], gk0 [4], gk1 [4];

   // Lane g runs G_g in the column phase and G_(g+4) in the diagonal phase.
   for (genvar g = 0; g < 4; g++) begin : g_lane
      localparam int BD = 4 + ((g + 1) % 4);
      localparam int CD = 8 + ((g + 2) % 4);
      localparam int DD = 12 + ((g + 3) % 4);
      logic       diag;
      logic [3:0] s0, s1;

      assign diag   = (phase == DIAG);
      assign s0     = SIGMA[sigma_idx][{diag, 2'(g), 1'b0}];
      assign s1     = SIGMA[sigma_idx][{diag, 2'(g), 1'b1}];
      assign ga[g]  = v_reg[g];
      assign gb[g]  = diag ? v_reg[BD] : v_reg[4 + g];
      assign gc[g]  = diag ? v_reg[CD] : v_reg[8 + g];
      assign gd[g]  = diag ? v_reg[DD] : v_reg[12 + g];
      assign gm0[g] = m_reg[s0];
      assign gm1[g] = m_reg[s1];
      assign gk0[g] = W'(blake_const(W, s1));
      assign gk1[g] = W'(blake_const(W, s0));

      blake_g_param #(.W(W)) u_g (
         .a     (ga[g]),
         .b     (gb[g]),
         .c     (gc[g]),
         .d     (gd[g]),
         .m0    (gm0[g]),
         .m1    (gm1[g]),
         .k0    (gk0[g]),
         .k1    (gk1[g]),
         .a_new (ya[g]),
         .b_new (yb[g]),
         .c_new (yc[g]),
         .d_new (yd[g])
      );
   end

   always_comb begin
      v_half = v_reg;
      for (int g = 0; g < 4; g++) begin
         v_half[g] = ya[g];
         if (phase == DIAG) begin
            v_half[4 + ((g + 1) % 4)]  = yb[g];
            v_half[8 + ((g + 2) % 4)]  = yc[g];
            v_half[12 + ((g + 3) % 4)] = yd[g];
         end else begin
            v_half[4 + g]  = yb[g];
            v_half[8 + g]  = yc[g];
            v_half[12 + g] = yd[g];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // A DONE-state handshake may take the next block in the same cycle.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (phase == DIAG && round_cnt == LAST_ROUND) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            accept    = in_valid && out_ready;
            if (out_ready) state_next = in_valid ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= COL;
         round_cnt <= '0;
         sigma_idx <= '0;
         for (int i = 0; i < 16; i++) begin
            v_reg[i] <= '0;
            m_reg[i] <= '0;
         end
      end else if (accept) begin
         phase     <= COL;
         round_cnt <= '0;
         sigma_idx <= '0;
         for (int i = 0; i < 16; i++) begin
            v_reg[i] <= in_v[W*i +: W];
            m_reg[i] <= in_m[W*i +: W];
         end
      end else if (state == RUN) begin
         v_reg <= v_half;
         if (phase == COL) begin
            phase <= DIAG;
         end else begin
            phase     <= COL;
            round_cnt <= round_cnt + 4'd1;
            sigma_idx <= (sigma_idx == 4'd9) ? 4'd0 : sigma_idx + 4'd1;
         end
      end
   end

   for (genvar i = 0; i < 16; i++) begin : g_out
      assign out_v[W*i +: W] = v_reg[i];
   end

endmodule

// File: tb/tb_blake_round_engine.sv
// tb/tb_blake_round_engine.sv - randomized self-checking bench for blake_round_engine against a BLAKE model
module tb_blake_round_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [511:0]  a_in_v, a_in_m, a_out_v;
   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [511:0]  b_in_v, b_in_m, b_out_v;
   logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
   logic [1023:0] c_in_v, c_in_m, c_out_v;

   blake_round_engine #(.W(32), .ROUNDS(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_v(a_in_v), .in_m(a_in_m), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_v(a_out_v), .busy(a_busy)
   );

   blake_round_engine #(.W(32), .ROUNDS(14)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_v(b_in_v), .in_m(b_in_m), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_v(b_out_v), .busy(b_busy)
   );

   blake_round_engine #(.W(64), .ROUNDS(16)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_v(c_in_v), .in_m(c_in_m), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_v(c_out_v), .busy(c_busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference tables: sigma rows as nibble strings, pi words for the constants.
   localparam logic [63:0] SIG_ROWS [10] = '{
      64'h0123456789ABCDEF, 64'hEA489FD61C02B753, 64'hB8C052FDAE367194, 64'h7931DCBE265A40F8,
      64'h905724AFE1BC683D, 64'h2C6A0B834D75FE19, 64'hC51FED4A0763928B, 64'hDB7EC13950F4862A,
      64'h6FE9B308C2D714A5, 64'hA2847615FB9E3CD0
   };
   localparam logic [63:0] PI_WORDS [16] = '{
      64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
      64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
      64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
      64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
   };
   localparam logic [31:0] IV256 [8] = '{
      32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
      32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
   };
   localparam logic [31:0] DIGEST [8] = '{
      32'h0ce8d4ef, 32'h4dd7cd8d, 32'h62dfded9, 32'hd4edb0a7,
      32'h74ae6a41, 32'h929a74da, 32'h23109e8f, 32'h11139c87
   };

   logic [63:0] mv [16];
   logic [63:0] mm [16];

   function automatic int sig(input int r, input int k);
      logic [63:0] row;
      row = SIG_ROWS[r % 10];
      return int'(row[60 - 4*k +: 4]);
   endfunction

   // BLAKE-256 constants are the 32-bit halves of the leading BLAKE-512 words.
   function automatic logic [63:0] cst(input int w, input int i);
      logic [63:0] p;
      if (w == 64) return PI_WORDS[i];
      p = PI_WORDS[i / 2];
      return (i % 2 == 0) ? {32'h0, p[63:32]} : {32'h0, p[31:0]};
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
      logic [63:0] mask;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      return ((x >> n) | (x << (w - n))) & mask;
   endfunction

   task automatic run_model(input int w, input int rounds);
      logic [63:0] mask;
      int rot [4];
      int i, ia, ib, ic, id, x0, x1;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      if (w == 64) rot = '{32, 25, 16, 11};
      else         rot = '{16, 12, 8, 7};
      for (int r = 0; r < rounds; r++) begin
         for (int j = 0; j < 8; j++) begin
            i  = j % 4;
            ia = i;
            ib = 4 + ((j < 4) ? i : (i + 1) % 4);
            ic = 8 + ((j < 4) ? i : (i + 2) % 4);
            id = 12 + ((j < 4) ? i : (i + 3) % 4);
            x0 = sig(r, 2*j);
            x1 = sig(r, 2*j + 1);
            mv[ia] = (mv[ia] + mv[ib] + (mm[x0] ^ cst(w, x1))) & mask;
            mv[id] = rotr(mv[id] ^ mv[ia], rot[0], w);
            mv[ic] = (mv[ic] + mv[id]) & mask;
            mv[ib] = rotr(mv[ib] ^ mv[ic], rot[1], w);
            mv[ia] = (mv[ia] + mv[ib] + (mm[x1] ^ cst(w, x0))) & mask;
            mv[id] = rotr(mv[id] ^ mv[ia], rot[2], w);
            mv[ic] = (mv[ic] + mv[id]) & mask;
            mv[ib] = rotr(mv[ib] ^ mv[ic], rot[3], w);
         end
      end
   endtask

   task automatic rand_block(input int w);
      for (int i = 0; i < 16; i++) begin
         mv[i] = (w == 64) ? {$urandom, $urandom} : {32'h0, $urandom};
         mm[i] = (w == 64) ? {$urandom, $urandom} : {32'h0, $urandom};
      end
   endtask

   function automatic logic [1023:0] pack_words(input bit use_m, input int w);
      logic [1023:0] p;
      logic [63:0]   x;
      p = '0;
      for (int i = 0; i < 16; i++) begin
         x = use_m ? mm[i] : mv[i];
         if (w == 64) p[64*i +: 64] = x;
         else         p[32*i +: 32] = x[31:0];
      end
      return p;
   endfunction

   task automatic check_out(input string tag, input logic [1023:0] got, input int w);
      for (int i = 0; i < 16; i++)
         check($sformatf("%s[%0d]", tag, i),
               (w == 64) ? got[64*i +: 64] : {32'h0, got[32*i +: 32]}, mv[i]);
   endtask

   task automatic a_run_block(input int stall);
      logic [1023:0] exp;
      int e;
      rand_block(32);
      a_in_v = 512'(pack_words(1'b0, 32));
      a_in_m = 512'(pack_words(1'b1, 32));
      run_model(32, 8);
      exp = pack_words(1'b0, 32);
      check("a idle in_ready", a_in_ready, 1);
      a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      check("a run busy", a_busy, 1);
      check("a run in_ready", a_in_ready, 0);
      e = 0;
      while (!a_out_valid && e < 100) begin
         @(negedge clk);
         e++;
      end
      check("a latency", e, 16);
      for (int s = 0; s < stall; s++) begin
         a_in_valid = 1'($urandom_range(0, 1));
         check("a stall out_valid", a_out_valid, 1);
         check("a stall in_ready", a_in_ready, 0);
         check("a stall out_v held", a_out_v == exp[511:0], 1);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      check_out("a out_v", a_out_v, 32);
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      check("a out_valid drop", a_out_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [1023:0] exp1;
      logic [63:0]   h;
      int e;
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_v = '0; a_in_m = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_v = '0; b_in_m = '0;
      c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_v = '0; c_in_m = '0;
      repeat (2) @(negedge clk);
      check("reset in_ready", a_in_ready, 1);
      check("reset out_valid", a_out_valid, 0);
      check("reset busy", a_busy, 0);
      check("reset out_v", |a_out_v, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 200; n++) a_run_block($urandom_range(0, 4));

      // Back-to-back: both handshakes held high.
      rand_block(32);
      a_in_v = 512'(pack_words(1'b0, 32));
      a_in_m = 512'(pack_words(1'b1, 32));
      run_model(32, 8);
      exp1 = pack_words(1'b0, 32);
      a_in_valid = 1'b1;
      a_out_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         check("b2b in_ready", a_in_ready, (c % 17 == 0));
         check("b2b out_valid", a_out_valid, (c > 0 && c % 17 == 0));
         if (a_out_valid) check("b2b out_v", a_out_v == exp1[511:0], 1);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      repeat (20) @(negedge clk);
      check("b2b drained busy", a_busy, 0);
      check("b2b drained in_ready", a_in_ready, 1);
      a_out_ready = 1'b0;

      // Long stall in DONE with in_valid asserted and a different block offered.
      rand_block(32);
      a_in_v = 512'(pack_words(1'b0, 32));
      a_in_m = 512'(pack_words(1'b1, 32));
      run_model(32, 8);
      exp1 = pack_words(1'b0, 32);
      a_in_valid = 1'b1;
      @(negedge clk);
      rand_block(32);
      a_in_v = 512'(pack_words(1'b0, 32));
      a_in_m = 512'(pack_words(1'b1, 32));
      run_model(32, 8);
      e = 0;
      while (!a_out_valid && e < 100) begin
         @(negedge clk);
         e++;
      end
      check("hold latency", e, 16);
      repeat (50) begin
         check("hold in_ready", a_in_ready, 0);
         check("hold out_valid", a_out_valid, 1);
         check("hold out_v", a_out_v == exp1[511:0], 1);
         @(negedge clk);
      end
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      a_in_valid  = 1'b0;
      check("hold next busy", a_busy, 1);
      check("hold next out_valid", a_out_valid, 0);
      e = 0;
      while (!a_out_valid && e < 100) begin
         @(negedge clk);
         e++;
      end
      check("hold next latency", e, 16);
      check_out("hold next out_v", a_out_v, 32);
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;

      // Reset in the fifth RUN cycle, then a clean block.
      rand_block(32);
      a_in_v = 512'(pack_words(1'b0, 32));
      a_in_m = 512'(pack_words(1'b1, 32));
      a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort out_valid", a_out_valid, 0);
      check("abort in_ready", a_in_ready, 1);
      check("abort busy", a_busy, 0);
      check("abort out_v", |a_out_v, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      a_run_block(2);

      // BLAKE-256 of the single byte 0x00, finalised here around the engine.
      for (int i = 0; i < 16; i++) mm[i] = '0;
      mm[0]  = 64'h0080_0000;
      mm[13] = 64'h1;
      mm[15] = 64'h8;
      for (int i = 0; i < 8; i++) mv[i] = {32'h0, IV256[i]};
      for (int i = 0; i < 4; i++) mv[8 + i] = cst(32, i);
      mv[12] = cst(32, 4) ^ 64'h8;
      mv[13] = cst(32, 5) ^ 64'h8;
      mv[14] = cst(32, 6);
      mv[15] = cst(32, 7);
      b_in_v = 512'(pack_words(1'b0, 32));
      b_in_m = 512'(pack_words(1'b1, 32));
      b_in_valid = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      e = 0;
      while (!b_out_valid && e < 100) begin
         @(negedge clk);
         e++;
      end
      check("digest latency", e, 28);
      for (int i = 0; i < 8; i++) begin
         h = {32'h0, IV256[i] ^ b_out_v[32*i +: 32] ^ b_out_v[32*(i + 8) +: 32]};
         check($sformatf("digest word %0d", i), h, {32'h0, DIGEST[i]});
      end
      b_out_ready = 1'b1;
      @(negedge clk);
      b_out_ready = 1'b0;

      // W=64, 16 rounds: sigma wraps after round 9.
      for (int n = 0; n < 4; n++) begin
         rand_block(64);
         c_in_v = pack_words(1'b0, 64);
         c_in_m = pack_words(1'b1, 64);
         run_model(64, 16);
         check("c idle in_ready", c_in_ready, 1);
         c_in_valid = 1'b1;
         @(negedge clk);
         c_in_valid = 1'b0;
         e = 0;
         while (!c_out_valid && e < 100) begin
            @(negedge clk);
            e++;
         end
         check("c latency", e, 32);
         check_out("c out_v", c_out_v, 64);
         c_out_ready = 1'b1;
         @(negedge clk);
         c_out_ready = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/blake_round_engine.md
Name: blake_round_engine

Overview:
- Iterative, parametrised BLAKE compression-round engine for the mining core.
- Accepts an initialised 16-word working state v and a 16-word message block m. Applies ROUNDS full BLAKE rounds and returns the final v.
- Finalisation (h ^ s ^ v[i] ^ v[i+8]) is performed downstream.
- Generalises the fixed 32-bit single-G datapath:
  - word width W (BLAKE-256 or BLAKE-512),
  - constant XOR and sigma permutation handled internally,
  - configurable round count,
  - valid/ready handshakes.

Parameters:
- W, 32, word width; only 32 or 64 are legal, anything else fails elaboration.
- ROUNDS, 8, full rounds per block: 8 for Blakecoin, 14 for BLAKE-256, 16 for BLAKE-512; legal range 1..16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input block valid
- in_ready  out  1  engine can accept a block
- in_v  in  16*W  initial state; word i at bits [W*i +: W]
- in_m  in  16*W  message block; same packing
- out_valid  out  1  out_v holds a finished result
- out_ready  in  1  consumer accepts result
- out_v  out  16*W  final state after ROUNDS rounds
- busy  out  1  high while rounds are in progress

Behaviour:
- Reset (async assert, sync release) gives the following values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0;
  - out_v=0, round counter=0, sigma index=0, phase=COL.
- Reset mid-operation discards the block; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_v and in_m, clear counters, go to RUN.
  - RUN: busy=1, in_ready=0. One half-round is evaluated per clock.
    - COL phase: G0..G3 on columns (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
    - DIAG phase: G4..G7 on (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
    - After the DIAG phase of round ROUNDS-1, the register takes its final value and the FSM goes to DONE.
  - DONE: out_valid=1, out_v stable.
    - On out_ready, out_valid drops next edge and the FSM returns to IDLE.
    - in_ready = out_ready while in DONE. A block accepted in the same cycle as the output handshake goes directly to RUN (back-to-back, no bubble).
- Latency: accept at edge k gives out_valid high after edge k+2*ROUNDS. Throughput is one block per 2*ROUNDS+1 cycles with back-to-back handshakes.
- in_valid is ignored while in RUN. in_ready is never high in RUN.
- out_valid holds with out_v unchanged until out_ready, regardless of in_valid.
- G function for message pair index j (0..7) in round r, with s = sigma[r mod 10], all additions mod 2^W:
  - a += b + (m[s[2j]] ^ C[s[2j+1]]); d = (d^a) >>> R1; c += d; b = (b^c) >>> R2
  - a += b + (m[s[2j+1]] ^ C[s[2j]]); d = (d^a) >>> R3; c += d; b = (b^c) >>> R4
- Rotation constants:
  - W=32: R1..R4 = 16, 12, 8, 7; C = BLAKE-256 constants.
  - W=64: R1..R4 = 32, 25, 16, 11; C = BLAKE-512 constants.
- Sigma index is a separate 0..9 counter that wraps 9→0 at each round end, so no modulo hardware is needed. Rounds 10..15 therefore reuse sigma 0..5.
- A half-round is fully combinational: four G instances, one register stage. No multicycle paths.

Decomposition:
- Shared package blake_pkg holds:
  - the sigma table (10x16 4-bit);
  - the BLAKE-256 and BLAKE-512 constant arrays C[16];
  - rotation-constant functions of W;
  - the FSM state enum {IDLE, RUN, DONE};
  - the phase enum {COL, DIAG}.
- Sub-module blake_g_param: parametrised W-bit G with inputs a, b, c, d, m0, m1, k0, k1, purely combinational.
  - Instantiated 4 times.
  - A mux selects column or diagonal word routing into and out of the instances.

Test Plan:
- W=32, ROUNDS=14, bench applies BLAKE-256 IV, counter and finalisation around the DUT for message 0x00 (one byte) → digest 0ce8d4ef4dd7cd8d62dfded9d4edb0a774ae6a41929a74da23109e8f11139c87.
- W=32, ROUNDS=8, 200 random (v, m) blocks with random out_ready stalls → out_v matches the C model bit-exactly. out_valid is high exactly 16 cycles after each accept, and held stable during stalls.
- Back-to-back, out_ready tied to 1 and in_valid tied to 1 → in_ready pulses once every 17 cycles, and the second accept coincides with the first output handshake.
- Assert rst_n low at cycle 5 of RUN → out_valid=0, in_ready=1 immediately. The next block's result matches the model, with no corruption from the aborted block.
- W=64, ROUNDS=16, random blocks → match the BLAKE-512 model, which exercises sigma wrap at round 10 and the 32/25/16/11 rotations.
- Hold out_ready=0 for 50 cycles in DONE while driving in_valid=1 → no accept, and out_v unchanged.
